// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//
// Round-robin arbiter that shares one 8-input encoded resource among eight
// requesters. The grant is registered, both as a one-hot vector and as a
// 3-bit binary index that uses the same encoding as the downstream 8-to-3
// encoder. A holder keeps the grant while its request stays high. When it
// drops its request, the grant moves straight to the next requester in
// circular order, with no idle cycle in between.
//
// Optional feature (compile-time macro RR_HOLD_TIMEOUT_EN):
//   When the macro is defined, a hold counter limits a holder to MAX_HOLD
//   consecutive grant cycles while any other requester is waiting. When it
//   is undefined, no counter logic exists.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per holder (2..255), timeout build only
//   CNT_W     hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous reset, active-high, dominates everything
//   en         in   1  arbiter enable; low releases any grant and idles
//   req        in   8  request vector, bit i = requester i
//   gnt        out  8  registered one-hot grant (or zero)
//   gnt_idx    out  3  registered binary index of the holder; holds when idle
//   gnt_valid  out  1  registered, equals |gnt
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] ptr;

    // Combinational selection results consumed by the state register
    logic [2:0] sel_from_ptr;
    logic [2:0] sel_after_holder;
    logic [2:0] holder_next;
    logic       holder_req;
    logic       any_req;

`ifdef RR_HOLD_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);
    logic [CNT_W-1:0] hold_cnt;
    logic             other_req;
`endif

    // A counter too narrow to reach MAX_HOLD-1 would never time out
    if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_params
        $error("rr_arbiter8: illegal MAX_HOLD/CNT_W combination");
    end

    // Returns the first set bit of r, scanning upward from start with wrap
    function automatic logic [2:0] first_from(input logic [7:0] r, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        first_from = start;
        found      = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = start + 3'(k);
            if (!found && r[idx]) begin
                first_from = idx;
                found      = 1'b1;
            end
        end
    endfunction

    // Candidate winners. A fresh grant from IDLE starts at ptr. A handover
    // starts just past the current holder.
    always_comb begin
        holder_next      = gnt_idx + 3'd1;
        holder_req       = req[gnt_idx];
        any_req          = |req;
        sel_from_ptr     = first_from(req, ptr);
        sel_after_holder = first_from(req, holder_next);
`ifdef RR_HOLD_TIMEOUT_EN
        // gnt is one-hot on the holder while in GRANT, so masking it leaves the other requesters
        other_req        = |(req & ~gnt);
`endif
    end

    // Arbiter FSM. All outputs are registered here, so gnt, gnt_idx and
    // gnt_valid always change together on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gnt       <= 8'h00;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else if (!en) begin
            // Disable releases immediately but keeps ptr, so fairness resumes where it left off
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state     <= GRANT;
                        gnt       <= 8'h01 << sel_from_ptr;
                        gnt_idx   <= sel_from_ptr;
                        gnt_valid <= 1'b1;
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (holder_req) begin
`ifdef RR_HOLD_TIMEOUT_EN
                        if (hold_cnt == HOLD_LIMIT && other_req) begin
                            // Forced handover; the holder is last in the scan, so another requester always wins
                            ptr      <= holder_next;
                            gnt      <= 8'h01 << sel_after_holder;
                            gnt_idx  <= sel_after_holder;
                            hold_cnt <= '0;
                        end else if (hold_cnt != HOLD_LIMIT) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
`endif
                    end else if (any_req) begin
                        ptr     <= holder_next;
                        gnt     <= 8'h01 << sel_after_holder;
                        gnt_idx <= sel_after_holder;
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end else begin
                        ptr       <= holder_next;
                        state     <= IDLE;
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
`ifdef RR_HOLD_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 8'h00;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-input encoded resource among 8 requesters.
- Accepts an 8-bit request vector and issues a registered one-hot grant plus its 3-bit binary index. The index has the same encoding as the 8-to-3 encoder output.
- Sits in front of the shared encoder/datapath. Rotating priority prevents starvation.

Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per holder; used only when the optional feature is compiled in; legal range 2..255.
- CNT_W, 8: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  arbiter enable; low forces release and idle.
- req  input  8  request vector; bit i = requester i.
- gnt  output  8  one-hot grant, registered.
- gnt_idx  output  3  binary index of the granted requester, registered.
- gnt_valid  output  1  high while gnt is nonzero.

Behaviour:
- One clock domain. Reset is synchronous and active-high. Reset dominates en and req.
- Reset values: gnt=8'b0, gnt_idx=3'd0, gnt_valid=0, state=IDLE, ptr=3'd0, hold_cnt=0.
- ptr is the search start: the first index examined is ptr, then ptr+1, and so on, modulo 8 (index 7 wraps to 0).
- Selection is the first req bit set, scanning upward from ptr. This is combinational and registered into gnt/gnt_idx.
- Invariants: gnt is always zero or one-hot; gnt_valid == |gnt; gnt_idx == encode(gnt) when gnt_valid=1, otherwise gnt_idx holds its last value.
- State IDLE:
  - If en=1 and req!=0: grant the selected requester on the next edge and go to GRANT. Latency from req to gnt is 1 cycle.
  - Otherwise stay in IDLE with gnt=0.
- State GRANT, holder h = gnt_idx:
  - req[h]=1 and en=1: keep the grant unchanged.
  - req[h]=0 and some other req set: hand over on the next edge to the first requester scanning from h+1. Back-to-back; no idle cycle.
  - req[h]=0 and req==0: gnt=0, go to IDLE.
  - On every handover or release, ptr <= h+1 (mod 8).
- en=0 in any state: gnt=0 and gnt_valid=0 on the next edge, state=IDLE, ptr unchanged, hold_cnt cleared.
- Simultaneous requests: exactly one is granted, and it is the one closest to ptr in circular order.
- A new request arriving while a grant is held is not granted until the holder releases (or times out, with the optional feature).
- A request dropping in the same cycle as a handover decision is evaluated on that cycle's sampled req value only.
- Reset asserted mid-grant: gnt=0 the next edge; ptr returns to 0.

Optional Feature:
- Macro: RR_HOLD_TIMEOUT_EN.
- Defined:
  - hold_cnt increments each GRANT cycle in which the holder keeps its grant, and clears on any grant change.
  - When hold_cnt == MAX_HOLD-1 and any other req bit is set, the grant is forcibly handed to the next requester scanning from h+1, and ptr <= h+1.
  - If no other requester is pending, the holder keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Not defined: no hold_cnt logic is synthesized; a holder keeps the grant for as long as its req stays high.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then en=1, req=8'h00 -> gnt=8'h00, gnt_valid=0, gnt_idx=0 for 10 cycles.
- Single one-hot sweep: en=1, req=1<<i for i=0..7, each held 3 cycles then dropped -> gnt=1<<i and gnt_idx=i one cycle after req rises; gnt=0 one cycle after req drops.
- Round-robin fairness: req=8'hFF, with each holder dropping its req for 1 cycle after 2 cycles of grant -> gnt_idx sequence 0,1,2,...,7,0 with no idle cycle between handovers.
- Wrap and skip: ptr=6 (after granting 5), req=8'b0000_0101 -> grant idx 0, then idx 2.
- Enable drop mid-grant: holder idx 3, en=0 for 1 cycle -> gnt=0 next edge; on en=1 with req=8'h08, idx 3 is re-granted after 1 cycle (ptr unchanged).
- Timeout (RR_HOLD_TIMEOUT_EN, MAX_HOLD=4): req=8'h03 held constantly -> idx 0 for 4 cycles, idx 1 for 4 cycles, then idx 0. With req=8'h01 only, idx 0 is held indefinitely.
